// File: rtl/muldiv_if.sv
// Request/response bundle for the sequential multiply/divide unit.
// The master drives requests and accepts results; the slave is the unit itself.
interface muldiv_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] c;
  logic        busy;

  modport master (
    output flush, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c, busy
  );

  modport slave (
    input  flush, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative 64-bit multiply / divide: shift-add MUL, restoring DIV/REM, one bit per cycle.
// Divide-by-zero, signed overflow and illegal opcodes complete on the accept edge.
module muldiv_seq (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_DIVU = 3'd2;
  localparam logic [2:0] OP_REM  = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  logic [1:0]  state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [2:0]  op_q, op_d;
  logic [63:0] a_q, a_d;
  logic [63:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] quo_q, quo_d;
  logic [63:0] dvs_q, dvs_d;
  logic [63:0] c_q, c_d;

  logic        accept;
  logic        sgn_op;
  logic [63:0] mag_a, mag_b;
  logic [64:0] rem_sh, diff;
  logic [63:0] acc_nx, quo_nx, dvs_nx;
  logic [63:0] q_fin, r_fin, result;

  assign bus.in_ready  = (state_q == S_IDLE) && !bus.flush;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.c         = c_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // One iteration of the datapath; acc holds product or partial remainder,
  // quo holds the shifting multiplier or dividend/quotient, dvs the multiplicand or divisor.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    sgn_op = (op_q == OP_DIV) || (op_q == OP_REM);
    mag_a  = (sgn_op && a_q[63]) ? -a_q : a_q;
    mag_b  = (sgn_op && b_q[63]) ? -b_q : b_q;
    rem_sh = {acc_q, quo_q[63]};
    diff   = rem_sh - {1'b0, dvs_q};
    acc_nx = acc_q;
    quo_nx = quo_q;
    dvs_nx = dvs_q;
    if (op_q == OP_MUL) begin
      acc_nx = acc_q + (quo_q[0] ? dvs_q : 64'd0);
      quo_nx = quo_q >> 1;
      dvs_nx = dvs_q << 1;
    end else if (!diff[64]) begin
      acc_nx = diff[63:0];
      quo_nx = {quo_q[62:0], 1'b1};
    end else begin
      acc_nx = rem_sh[63:0];
      quo_nx = {quo_q[62:0], 1'b0};
    end
    q_fin = (sgn_op && (a_q[63] ^ b_q[63])) ? -quo_nx : quo_nx;
    r_fin = (sgn_op && a_q[63]) ? -acc_nx : acc_nx;
    case (op_q)
      OP_MUL:          result = acc_nx;
      OP_DIV, OP_DIVU: result = q_fin;
      OP_REM, OP_REMU: result = r_fin;
      default:         result = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    c_d     = c_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = bus.op;
          a_d   = bus.a;
          b_d   = bus.b;
          cnt_d = 7'd0;
          if (bus.op > OP_REMU) begin
            c_d     = 64'd0;
            state_d = S_DONE;
          end else if ((bus.op != OP_MUL) && (bus.b == 64'd0)) begin
            c_d     = ((bus.op == OP_REM) || (bus.op == OP_REMU)) ? bus.a : '1;
            state_d = S_DONE;
          end else if (((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                       (bus.a == INT_MIN) && (bus.b == '1)) begin
            c_d     = (bus.op == OP_DIV) ? bus.a : 64'd0;
            state_d = S_DONE;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'd0) begin
          // Setup cycle: load magnitudes so the 64 iterations run unsigned.
          acc_d = 64'd0;
          quo_d = (op_q == OP_MUL) ? b_q : mag_a;
          dvs_d = (op_q == OP_MUL) ? a_q : mag_b;
        end else begin
          acc_d = acc_nx;
          quo_d = quo_nx;
          dvs_d = dvs_nx;
          if (cnt_q == 7'd64) begin
            c_d     = result;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          c_d     = 64'd0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = 7'd0;
      c_d     = 64'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      op_q    <= 3'd0;
      a_q     <= 64'd0;
      b_q     <= 64'd0;
      acc_q   <= 64'd0;
      quo_q   <= 64'd0;
      dvs_q   <= 64'd0;
      c_q     <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic vectors, fast paths, flush, hold and reset.
// Latency is counted in rising edges after the accept edge (normal ops 65, fast paths 0).
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  muldiv_if bus ();

  muldiv_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [2:0] OP_MUL = 3'd0, OP_DIV = 3'd1, OP_DIVU = 3'd2,
                         OP_REM = 3'd3, OP_REMU = 3'd4;

  // Present one request, scramble the inputs after accept, wait (bounded) for out_valid.
  task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat);
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.op = 3'd0;
    bus.a = 64'hDEAD_BEEF_0BAD_F00D; bus.b = 64'h0000_0000_0000_0001;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.c;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s timeout: out_valid=%b after %0d edges, required 1", name, bus.out_valid, lat);
    end
  endtask

  // Full transaction with out_ready high: result, latency, then clean return to IDLE.
  task automatic exec_vec(input string name, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_c, input int exp_lat);
    logic [63:0] res;
    int          lat;
    run_op(name, op, a, b, res, lat);
    n_checks++;
    if (res !== exp_c) begin
      n_fail++;
      $display("FAIL %s c: got %h required %h", name, res, exp_c);
    end
    n_checks++;
    if (lat !== exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 64'd0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: out_valid=%b c=%h in_ready=%b busy=%b required 0/0/1/0",
               name, bus.out_valid, bus.c, bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 64'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b c=%h busy=%b required 0/0/0", bus.out_valid, bus.c, bus.busy);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
    end
  endtask

  task automatic test_mul();
    exec_vec("mul_7_neg3", OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    exec_vec("mul_wrap", OP_MUL, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
             64'h0000_0002_0000_0001, 65);
    exec_vec("mul_by_zero", OP_MUL, 64'd12345, 64'd0, 64'd0, 65);
  endtask

  task automatic test_div_signed();
    exec_vec("div_m20_3", OP_DIV, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    exec_vec("rem_m20_3", OP_REM, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    exec_vec("div_20_m3", OP_DIV, 64'd20, -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 65);
    exec_vec("rem_20_m3", OP_REM, 64'd20, -64'sd3, 64'd2, 65);
  endtask

  task automatic test_div_unsigned();
    exec_vec("divu_100_7", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
    exec_vec("remu_100_7", OP_REMU, 64'd100, 64'd7, 64'd2, 65);
    exec_vec("divu_max_2", OP_DIVU, '1, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 65);
    exec_vec("remu_max_2", OP_REMU, '1, 64'd2, 64'd1, 65);
    exec_vec("divu_max_max", OP_DIVU, '1, '1, 64'd1, 65);
  endtask

  task automatic test_fast_path();
    exec_vec("divu_by0", OP_DIVU, 64'd5, 64'd0, '1, 0);
    exec_vec("remu_by0", OP_REMU, 64'd5, 64'd0, 64'd5, 0);
    exec_vec("div_by0", OP_DIV, -64'sd5, 64'd0, '1, 0);
    exec_vec("rem_by0", OP_REM, -64'sd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 0);
    exec_vec("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 0);
    exec_vec("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0, 0);
    exec_vec("illegal_op5", 3'd5, 64'd9, 64'd3, 64'd0, 0);
    exec_vec("illegal_op7", 3'd7, 64'd9, 64'd0, 64'd0, 0);
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.op = OP_DIVU; bus.a = 64'd100; bus.b = 64'd7; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.c !== 64'd0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_edge30: busy=%b out_valid=%b c=%h in_ready=%b required 0/0/0/0",
               bus.busy, bus.out_valid, bus.c, bus.in_ready);
    end
    @(negedge clk);
    bus.flush = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_edge31: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    // flush together with a request must accept nothing
    @(negedge clk);
    bus.flush = 1'b1; bus.in_valid = 1'b1;
    bus.op = OP_DIVU; bus.a = 64'd100; bus.b = 64'd0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_accept: busy=%b out_valid=%b required 0/0", bus.busy, bus.out_valid);
    end
    @(negedge clk);
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    exec_vec("divu_after_flush", OP_DIVU, 64'd100, 64'd7, 64'd14, 65);
  endtask

  task automatic test_hold();
    logic [63:0] res;
    int          lat;
    int          bad;
    bus.out_ready = 1'b0;
    run_op("hold_mul", OP_MUL, 64'd3, 64'd4, res, lat);
    n_checks++;
    if (res !== 64'd12 || lat !== 65) begin
      n_fail++;
      $display("FAIL hold_mul: c=%h lat=%0d required 000000000000000c/65", res, lat);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b1 || bus.c !== 64'd12) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
    end
    // release with a request already waiting: it must not be taken on the release edge
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    bus.op = OP_DIVU; bus.a = 64'd1; bus.b = 64'd0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.c !== 64'd0) begin
      n_fail++;
      $display("FAIL release_no_accept: out_valid=%b busy=%b c=%h required 0/0/0",
               bus.out_valid, bus.busy, bus.c);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [63:0] res;
    int          lat;
    int          pulses;
    @(negedge clk);
    bus.op = OP_MUL; bus.a = 64'd3; bus.b = 64'd4; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 64'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: out_valid=%b c=%h busy=%b required 0/0/0", bus.out_valid, bus.c, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_discard: %0d out_valid cycles, required 0", pulses);
    end
    bus.out_ready = 1'b0;
    run_op("reset_done_op", OP_REMU, 64'd9, 64'd0, res, lat);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.c !== 64'd0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_done: out_valid=%b c=%h busy=%b required 0/0/0", bus.out_valid, bus.c, bus.busy);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_recover: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.a         = 64'd0;
    bus.b         = 64'd0;
    bus.out_ready = 1'b1;

    test_reset();
    test_mul();
    test_div_signed();
    test_div_unsigned();
    test_fast_path();
    test_flush();
    test_hold();
    test_async_reset();
    exec_vec("back_to_back_mul", OP_MUL, 64'd6, 64'd7, 64'd42, 65);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
